// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes,
// controller states and the per-operation flags latched at issue.
package muldiv_ctrl_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      MDS_IDLE = 2'd0,
      MDS_CALC = 2'd1,
      MDS_FIX  = 2'd2
   } mds_e;

   typedef struct packed {
      logic is_div;
      logic neg_q;   // product or quotient gets negated
      logic neg_r;   // remainder gets negated
      logic dbz;
   } md_flags_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: radix-2 shift-add multiply or
// restoring divide on a {upper, lower} double-width accumulator.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   d,
   input  logic               is_div,
   output logic [2*WIDTH-1:0] acc_nxt
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   mul_hi;
   logic [WIDTH:0]   top;
   logic             ge;
   logic [WIDTH-1:0] diff;

   always_comb begin
      // multiply: multiplier sits in the low half and is consumed LSB first
      sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, d};
      mul_hi = acc[0] ? sum : {1'b0, acc[2*WIDTH-1:WIDTH]};
      // divide: shifted partial remainder can be WIDTH+1 bits wide
      top    = acc[2*WIDTH-1:WIDTH-1];
      ge     = (top >= {1'b0, d});
      diff   = top[WIDTH-1:0] - d;
      if (is_div)
         acc_nxt = ge ? {diff, acc[WIDTH-2:0], 1'b1}
                      : {top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         acc_nxt = {mul_hi, acc[WIDTH-1:1]};
   end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU controller owning the architectural HI/LO
// registers; busy stalls dependents until the FIX-state commit.
module muldiv_ctrl
   import muldiv_ctrl_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(ITER);

   mds_e               state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0]   dvs, a_lat;
   md_flags_t          fl;

   logic               sgn_op, div_op;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      sgn_op = (md_op == MD_MULT) || (md_op == MD_DIV);
      div_op = (md_op == MD_DIV)  || (md_op == MD_DIVU);
      abs_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
      abs_b  = (sgn_op && b[WIDTH-1]) ? -b : b;
      prod   = fl.neg_q ? -acc : acc;
   end

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .acc    (acc),
      .d      (dvs),
      .is_div (fl.is_div),
      .acc_nxt(acc_nxt)
   );

   assign busy = (state != MDS_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= MDS_IDLE;
         cnt   <= '0;
         acc   <= '0;
         dvs   <= '0;
         a_lat <= '0;
         fl    <= '0;
         hi    <= '0;
         lo    <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            MDS_IDLE: begin
               if (start && !flush) begin
                  case (md_op_e'(md_op))
                     MD_MTHI: hi <= a;
                     MD_MTLO: lo <= a;
                     MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                        acc       <= {{WIDTH{1'b0}}, abs_a};
                        dvs       <= abs_b;
                        a_lat     <= a;
                        fl.is_div <= div_op;
                        fl.neg_q  <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        fl.neg_r  <= sgn_op && a[WIDTH-1];
                        fl.dbz    <= div_op && (b == '0);
                        cnt       <= '0;
                        state     <= MDS_CALC;
                     end
                     default: ;
                  endcase
               end
            end
            MDS_CALC: begin
               if (flush) begin
                  state <= MDS_IDLE;
               end else begin
                  acc <= acc_nxt;
                  cnt <= cnt + 1'b1;
                  if (cnt == CW'(ITER - 1))
                     state <= MDS_FIX;
               end
            end
            MDS_FIX: begin
               state <= MDS_IDLE;
               if (!flush) begin
                  done <= 1'b1;
                  if (fl.dbz) begin
                     lo <= '1;
                     hi <= a_lat;
                  end else if (fl.is_div) begin
                     lo <= fl.neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                     hi <= fl.neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                  end else begin
                     lo <= prod[WIDTH-1:0];
                     hi <= prod[2*WIDTH-1:WIDTH];
                  end
               end
            end
            default: state <= MDS_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench: expected HI/LO pushed at issue, popped by a monitor on done.
module tb_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, start, flush;
   logic [2:0]  md_op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   typedef struct {
      string       nm;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   done_cnt = 0;
   int   all_busy = 1;

   muldiv_ctrl #(.WIDTH(32), .ITER(32)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .md_op(md_op),
      .a    (a),
      .b    (b),
      .flush(flush),
      .busy (busy),
      .done (done),
      .hi   (hi),
      .lo   (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && done) begin
         exp_t e;
         done_cnt++;
         if (q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk({e.nm, "_hi"}, hi, e.hi);
            chk({e.nm, "_lo"}, lo, e.lo);
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      md_op = op; a = av; b = bv; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic push(input string nm, input logic [31:0] h, input logic [31:0] l);
      exp_t e;
      e.nm = nm; e.hi = h; e.lo = l;
      q.push_back(e);
   endtask

   // exp_lat == 0 skips the latency comparison
   task automatic wait_done(input string nm, input int exp_lat);
      int n = 0;
      bit seen = 0;
      while (!seen && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (done) seen = 1;
         else if (!busy) all_busy = 0;
      end
      if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
      else if (exp_lat != 0) chk({nm, "_latency"}, n, exp_lat);
   endtask

   task automatic run(input string nm, input logic [2:0] op, input logic [31:0] av,
                      input logic [31:0] bv, input logic [31:0] h, input logic [31:0] l);
      push(nm, h, l);
      issue(op, av, bv);
      wait_done(nm, 33);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; md_op = 3'd0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      rst_n = 1'b1;

      run("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run("mult_neg",  3'd0, -32'sd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
      run("div_neg",   3'd2, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run("divu_zero", 3'd3, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF);
      run("div_ovf",   3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
      chk("busy_until_done", all_busy, 1);

      issue(3'd4, 32'h12345678, 32'd0);
      @(negedge clk);
      chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_busy", {31'd0, busy}, 32'd0);
      issue(3'd5, 32'h9ABCDEF0, 32'd0);
      @(negedge clk);
      chk("mtlo_lo", lo, 32'h9ABCDEF0);
      chk("mtlo_hi_kept", hi, 32'h12345678);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);

      // start with flush in IDLE is dropped
      @(negedge clk);
      md_op = 3'd4; a = 32'hDEADBEEF; start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("idle_flush_hi", hi, 32'h12345678);
      chk("idle_flush_busy", {31'd0, busy}, 32'd0);

      // second start while busy is ignored
      push("divu_busy", 32'd6, 32'd142);
      issue(3'd3, 32'd1000, 32'd7);
      repeat (5) @(negedge clk);
      md_op = 3'd1; a = 32'd2; b = 32'd3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("divu_busy", 0);

      // flush mid-CALC: no commit, no done
      issue(3'd3, 32'd50, 32'd3);
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_hi", hi, 32'd6);
      chk("flush_lo", lo, 32'd142);
      repeat (40) @(posedge clk);
      run("multu_6x7", 3'd1, 32'd6, 32'd7, 32'd0, 32'd42);

      // async reset between edges mid-CALC
      issue(3'd1, 32'd9, 32'd9);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_hi", hi, 32'd0);
      chk("arst_lo", lo, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      @(negedge clk);

      chk("done_pulses", done_cnt, 7);
      chk("sb_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
